// File: rtl/mac_seq_ctrl.sv
// Sequenced signed vector MAC: accumulates len beats of pr-lane dot products
// and presents the sum with a valid/ready result handshake.
module mac_seq_ctrl #(
  parameter int unsigned bw      = 8,
  parameter int unsigned pr      = 8,
  parameter int unsigned bw_psum = 2*bw+3,
  parameter int unsigned cnt_bw  = 6,
  parameter int unsigned acc_bw  = bw_psum+cnt_bw
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [cnt_bw-1:0]        len,
  output logic                     busy,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [pr*bw-1:0]         a,
  input  logic [pr*bw-1:0]         b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [acc_bw-1:0]        out
);

  localparam int unsigned pw = 2*bw;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                     state;
  logic signed [acc_bw-1:0]   acc;
  logic        [cnt_bw-1:0]   cnt;
  logic        [cnt_bw-1:0]   len_q;
  logic signed [pw-1:0]       prod [pr];
  logic signed [bw_psum-1:0]  beat;
  logic                       last_beat;

  // Per-lane signed products summed into one beat-wide partial sum
  always_comb begin
    beat = '0;
    for (int i = 0; i < pr; i++) begin
      prod[i] = pw'(signed'(a[bw*i +: bw])) * pw'(signed'(b[bw*i +: bw]));
      beat    = beat + bw_psum'(prod[i]);
    end
  end

  assign last_beat = (cnt == cnt_bw'(len_q - cnt_bw'(1)));
  assign in_ready  = (state == ACC);
  assign out       = acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      len_q     <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && (len != '0)) begin
            len_q <= len;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ACC;
          end
        end
        ACC: begin
          if (in_valid) begin
            acc <= acc + acc_bw'(beat);
            cnt <= cnt + cnt_bw'(1);
            if (last_beat) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Self-checking bench for mac_seq_ctrl: directed corner jobs plus randomized
// jobs compared against an integer dot-product reference model.
module tb_mac_seq_ctrl;

  localparam int unsigned BW   = 8;
  localparam int unsigned PR   = 8;
  localparam int unsigned CNTW = 6;
  localparam int unsigned ACCW = 2*BW+3+CNTW;
  localparam int unsigned VW   = PR*BW;

  logic            clk;
  logic            reset;
  logic            start;
  logic [CNTW-1:0] len;
  logic            busy;
  logic            in_valid;
  logic            in_ready;
  logic [VW-1:0]   a;
  logic [VW-1:0]   b;
  logic            out_valid;
  logic            out_ready;
  logic [ACCW-1:0] out;

  int     checks;
  int     errors;
  longint exp_sum;
  bit     noise;

  mac_seq_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .out(out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic longint dot(input logic [VW-1:0] av, input logic [VW-1:0] bv);
    longint s;
    logic signed [BW-1:0] x;
    logic signed [BW-1:0] y;
    s = 0;
    for (int i = 0; i < PR; i++) begin
      x = av[BW*i +: BW];
      y = bv[BW*i +: BW];
      s = s + longint'(x) * longint'(y);
    end
    return s;
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    v = {$urandom, $urandom};
    if ($urandom_range(0, 7) == 0) v = {PR{8'h80}};
    return v;
  endfunction

  task automatic do_start(input logic [CNTW-1:0] l);
    start = 1'b1;
    len   = l;
    @(negedge clk);
    start   = 1'b0;
    len     = CNTW'($urandom);
    exp_sum = 0;
  endtask

  task automatic send_beat(input logic [VW-1:0] av, input logic [VW-1:0] bv, input int gap);
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        len   = CNTW'($urandom);
      end
      @(negedge clk);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL beat_ready: in_ready=%b required 1", in_ready);
    end
    in_valid = 1'b1;
    a = av;
    b = bv;
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b0;
    exp_sum  = exp_sum + dot(av, bv);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: busy=%b required 0", busy); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: in_ready=%b required 0", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: out_valid=%b required 0", out_valid); end
    checks++;
    if (out !== '0) begin errors++; $display("FAIL reset_out: out=%0h required 0", out); end
  endtask

  task automatic test_single_beat();
    do_start(CNTW'(1));
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_ready: in_ready=%b busy=%b required 1/1", in_ready, busy);
    end
    send_beat({PR{8'h01}}, {PR{8'h02}}, 0);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_valid: out_valid=%b in_ready=%b required 1/0", out_valid, in_ready);
    end
    checks++;
    if (out !== ACCW'(16)) begin errors++; $display("FAIL single_out: out=%0d required 16", out); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_release: out_valid=%b busy=%b required 0/0", out_valid, busy);
    end
  endtask

  task automatic test_max_magnitude();
    do_start(CNTW'(63));
    for (int k = 0; k < 63; k++) send_beat({PR{8'h80}}, {PR{8'h80}}, 0);
    checks++;
    if (out_valid !== 1'b1 || out !== 25'h07E0000 || out !== ACCW'(exp_sum)) begin
      errors++;
      $display("FAIL max_out: out_valid=%b out=%0h required 1/07e0000", out_valid, out);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_mixed_sign();
    do_start(CNTW'(2));
    send_beat({PR{8'h7F}}, {PR{8'hFF}}, 0);
    send_beat({PR{8'h7F}}, {PR{8'hFF}}, 1);
    checks++;
    if (out_valid !== 1'b1 || out !== 25'h1FFF810) begin
      errors++;
      $display("FAIL mixed_out: out_valid=%b out=%0h required 1/1fff810", out_valid, out);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [ACCW-1:0] held;
    int hs;
    do_start(CNTW'(3));
    for (int k = 0; k < 3; k++) send_beat(rand_vec(), rand_vec(), 2);
    held = out;
    checks++;
    if (out_valid !== 1'b1 || out !== ACCW'(exp_sum)) begin
      errors++;
      $display("FAIL bp_out: out_valid=%b out=%0h required 1/%0h", out_valid, out, ACCW'(exp_sum));
    end
    for (int c = 0; c < 5; c++) begin
      start = (c == 2);
      len   = CNTW'(5);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out !== held || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold: cycle %0d out_valid=%b out=%0h in_ready=%b required 1/%0h/0",
                 c, out_valid, out, in_ready, held);
      end
    end
    start = 1'b0;
    hs = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (out_valid === 1'b1) hs++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    checks++;
    if (hs != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_handshakes: handshakes=%0d busy=%b required 1/0", hs, busy);
    end
  endtask

  task automatic test_random_jobs();
    int l;
    noise = 1'b1;
    for (int j = 0; j < 12; j++) begin
      l = $urandom_range(1, 12);
      do_start(CNTW'(l));
      for (int k = 0; k < l; k++) send_beat(rand_vec(), rand_vec(), $urandom_range(0, 2));
      start = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out !== ACCW'(exp_sum)) begin
        errors++;
        $display("FAIL rand_job%0d: len=%0d out_valid=%b out=%0h required 1/%0h",
                 j, l, out_valid, out, ACCW'(exp_sum));
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL rand_release%0d: out_valid=%b busy=%b required 0/0", j, out_valid, busy);
      end
    end
    noise = 1'b0;
  endtask

  task automatic test_reset_mid_job();
    do_start(CNTW'(4));
    send_beat(rand_vec(), rand_vec(), 0);
    send_beat(rand_vec(), rand_vec(), 1);
    reset = 1'b1;
    start = 1'b1;
    len   = CNTW'(2);
    in_valid = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 || out !== '0) begin
      errors++;
      $display("FAIL midreset_state: busy=%b in_ready=%b out_valid=%b out=%0h required 0/0/0/0",
               busy, in_ready, out_valid, out);
    end
    do_start(CNTW'(1));
    send_beat({PR{8'h01}}, {PR{8'h01}}, 0);
    checks++;
    if (out_valid !== 1'b1 || out !== ACCW'(8)) begin
      errors++;
      $display("FAIL midreset_out: out_valid=%b out=%0d required 1/8", out_valid, out);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_len_zero();
    start = 1'b1;
    len   = '0;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      checks++;
      if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL len_zero: cycle %0d busy=%b in_ready=%b out_valid=%b required 0/0/0",
                 c, busy, in_ready, out_valid);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0; exp_sum = 0; noise = 1'b0;
    reset = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0;
    a = '0; b = '0; out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_beat();
    test_max_magnitude();
    test_mixed_sign();
    test_backpressure();
    test_random_jobs();
    test_reset_mid_job();
    test_len_zero();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end

endmodule
